// File: rtl/key_priority_encoder_if.sv
// Key encoder bus: raw key vector in, encoded key state and press/release event handshake out.
// master = encoder side, slave = key source / note sequencer side.
interface key_priority_encoder_if #(
    parameter int WIDTH = 8
);
    localparam int OUT_W = $clog2(WIDTH);

    logic             enable;
    logic [WIDTH-1:0] data_in;
    logic [OUT_W-1:0] data_out;
    logic             key_valid;
    logic             key_multi;
    logic             ev_valid;
    logic             ev_ready;
    logic [OUT_W-1:0] ev_code;
    logic             ev_press;
    logic             ev_overrun;

    modport master (
        input  enable, data_in, ev_ready,
        output data_out, key_valid, key_multi, ev_valid, ev_code, ev_press, ev_overrun
    );

    modport slave (
        output enable, data_in, ev_ready,
        input  data_out, key_valid, key_multi, ev_valid, ev_code, ev_press, ev_overrun
    );
endinterface

// File: rtl/key_priority_encoder.sv
// Debounced highest-index-priority key encoder with press/release events on a valid/ready handshake.
// Optional KEY_ENC_HOLD_LAST_EN: data_out keeps the last nonzero code while no key is committed.
module key_priority_encoder #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                   clk,
    input logic                   reset,
    key_priority_encoder_if.master bus
);
    localparam int OUT_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit IMMEDIATE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic {
        IDLE,
        SETTLE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] committed;
    logic [WIDTH-1:0] candidate;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;

    logic             commit;
    logic [WIDTH-1:0] commit_vec;

    logic             ev_valid_q;
    logic [OUT_W-1:0] ev_code_q;
    logic             ev_press_q;
    logic             ev_overrun_q;

    logic [OUT_W-1:0] committed_code;

    function automatic logic [OUT_W-1:0] encode(input logic [WIDTH-1:0] v);
        logic [OUT_W-1:0] code;
        code = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (v[i]) code = OUT_W'(i);
        end
        return code;
    endfunction

    assign count_inc = count + CNT_ONE;

    // Commit decision is pulled out of the FSM so the event path sees the same edge's commit.
    always_comb begin
        commit     = 1'b0;
        commit_vec = candidate;
        if (bus.enable) begin
            case (state)
                IDLE: begin
                    if (IMMEDIATE && (bus.data_in != committed)) begin
                        commit     = 1'b1;
                        commit_vec = bus.data_in;
                    end
                end
                SETTLE: begin
                    if ((bus.data_in != committed) && (bus.data_in == candidate) &&
                        (count_inc == CNT_TARGET)) begin
                        commit     = 1'b1;
                        commit_vec = candidate;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            committed    <= '0;
            candidate    <= '0;
            count        <= '0;
            ev_valid_q   <= 1'b0;
            ev_code_q    <= '0;
            ev_press_q   <= 1'b0;
            ev_overrun_q <= 1'b0;
        end else begin
            if (!bus.enable) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.data_in != committed && !IMMEDIATE) begin
                            state     <= SETTLE;
                            candidate <= bus.data_in;
                            count     <= CNT_ONE;
                        end
                    end
                    SETTLE: begin
                        if (bus.data_in == committed) begin
                            state <= IDLE;
                            count <= '0;
                        end else if (bus.data_in != candidate) begin
                            candidate <= bus.data_in;
                            count     <= CNT_ONE;
                        end else if (commit) begin
                            state <= IDLE;
                            count <= '0;
                        end else begin
                            count <= count_inc;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end

            if (commit) begin
                committed <= commit_vec;
            end

            // A pending event not accepted on a commit edge is lost; acceptance on the same edge is not an overrun.
            if (commit) begin
                ev_valid_q <= 1'b1;
                ev_code_q  <= encode(commit_vec);
                ev_press_q <= |commit_vec;
                if (ev_valid_q && !bus.ev_ready) ev_overrun_q <= 1'b1;
            end else if (ev_valid_q && bus.ev_ready) begin
                ev_valid_q <= 1'b0;
            end
        end
    end

    assign committed_code = encode(committed);

`ifdef KEY_ENC_HOLD_LAST_EN
    logic [OUT_W-1:0] last_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_code <= '0;
        end else if (commit && (|commit_vec)) begin
            last_code <= encode(commit_vec);
        end
    end

    assign bus.data_out = (|committed) ? committed_code : last_code;
`else
    assign bus.data_out = committed_code;
`endif

    assign bus.key_valid  = |committed;
    assign bus.key_multi  = |(committed & (committed - WIDTH'(1)));
    assign bus.ev_valid   = ev_valid_q;
    assign bus.ev_code    = ev_code_q;
    assign bus.ev_press   = ev_press_q;
    assign bus.ev_overrun = ev_overrun_q;
endmodule

// File: tb/tb_key_priority_encoder.sv
// Bench for key_priority_encoder: directed scenarios then random key traffic against a sample-window model.
module tb_key_priority_encoder;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    key_priority_encoder_if #(.WIDTH(W)) bus ();

    key_priority_encoder #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: the committed vector changes when the last D enabled samples agree on a value other than it.
    logic [W-1:0] q[$];
    logic [W-1:0] m_committed = '0;
    bit           m_ev_valid = 0;
    int           m_ev_code = 0;
    bit           m_ev_press = 0;
    bit           m_overrun = 0;
    int           m_last = 0;

    function automatic int hi_index(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit           do_commit;
        logic [W-1:0] nv;
        do_commit = 0;
        nv = '0;
        if (reset) begin
            q.delete();
            m_committed = '0;
            m_ev_valid = 0;
            m_ev_code = 0;
            m_ev_press = 0;
            m_overrun = 0;
            m_last = 0;
            return;
        end
        if (!bus.enable) begin
            q.delete();
        end else begin
            q.push_back(bus.data_in);
            if (q.size() > D) void'(q.pop_front());
            if (q.size() == D) begin
                do_commit = (q[0] != m_committed);
                foreach (q[i]) if (q[i] != q[0]) do_commit = 0;
            end
        end
        if (do_commit) begin
            nv = q[0];
            q.delete();
            if (m_ev_valid && !bus.ev_ready) m_overrun = 1;
            m_ev_valid = 1;
            m_ev_code = hi_index(nv);
            m_ev_press = (nv != 0);
            m_committed = nv;
            if (nv != 0) m_last = hi_index(nv);
        end else if (m_ev_valid && bus.ev_ready) begin
            m_ev_valid = 0;
        end
    endtask

    task automatic compare_all();
        int exp_out;
`ifdef KEY_ENC_HOLD_LAST_EN
        exp_out = (m_committed != 0) ? hi_index(m_committed) : m_last;
`else
        exp_out = (m_committed != 0) ? hi_index(m_committed) : 0;
`endif
        check("data_out", 64'(bus.data_out), 64'(exp_out));
        check("key_valid", 64'(bus.key_valid), 64'(m_committed != 0));
        check("key_multi", 64'(bus.key_multi), 64'($countones(m_committed) >= 2));
        check("ev_valid", 64'(bus.ev_valid), 64'(m_ev_valid));
        check("ev_overrun", 64'(bus.ev_overrun), 64'(m_overrun));
        if (m_ev_valid) begin
            check("ev_code", 64'(bus.ev_code), 64'(m_ev_code));
            check("ev_press", 64'(bus.ev_press), 64'(m_ev_press));
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    initial begin
        int len;
        logic [W-1:0] v;

        bus.enable   = 1'b1;
        bus.data_in  = '0;
        bus.ev_ready = 1'b1;
        reset        = 1'b1;
        tick(2);
        check("rst_data_out", 64'(bus.data_out), 64'd0);
        check("rst_ev_valid", 64'(bus.ev_valid), 64'd0);
        check("rst_ev_code", 64'(bus.ev_code), 64'd0);
        check("rst_ev_press", 64'(bus.ev_press), 64'd0);
        reset = 1'b0;
        tick(1);

        // Single key 3: commits on the 4th sampled edge, event taken immediately.
        bus.data_in = 8'h08;
        tick(3);
        check("k3_early_ev_valid", 64'(bus.ev_valid), 64'd0);
        check("k3_early_key_valid", 64'(bus.key_valid), 64'd0);
        tick(1);
        check("k3_data_out", 64'(bus.data_out), 64'd3);
        check("k3_key_valid", 64'(bus.key_valid), 64'd1);
        check("k3_ev_valid", 64'(bus.ev_valid), 64'd1);
        check("k3_ev_code", 64'(bus.ev_code), 64'd3);
        check("k3_ev_press", 64'(bus.ev_press), 64'd1);
        tick(1);
        check("k3_ev_taken", 64'(bus.ev_valid), 64'd0);

        bus.data_in = 8'h00;
        tick(6);

        // Short glitch must be filtered.
        bus.data_in = 8'h10;
        tick(2);
        bus.data_in = 8'h00;
        tick(5);
        check("glitch_ev_valid", 64'(bus.ev_valid), 64'd0);
        check("glitch_key_valid", 64'(bus.key_valid), 64'd0);

        // Multi-key then release.
        bus.data_in = 8'h81;
        tick(5);
        check("multi_data_out", 64'(bus.data_out), 64'd7);
        check("multi_key_multi", 64'(bus.key_multi), 64'd1);
        bus.data_in = 8'h00;
        tick(4);
        check("rel_ev_valid", 64'(bus.ev_valid), 64'd1);
        check("rel_ev_press", 64'(bus.ev_press), 64'd0);
        check("rel_ev_code", 64'(bus.ev_code), 64'd0);
        check("rel_key_valid", 64'(bus.key_valid), 64'd0);
`ifdef KEY_ENC_HOLD_LAST_EN
        check("rel_data_out", 64'(bus.data_out), 64'd7);
`else
        check("rel_data_out", 64'(bus.data_out), 64'd0);
`endif
        tick(2);

        // Consumer stalled: second commit overwrites the pending event.
        bus.ev_ready = 1'b0;
        bus.data_in  = 8'h02;
        tick(4);
        check("ovr_first_code", 64'(bus.ev_code), 64'd1);
        check("ovr_first_overrun", 64'(bus.ev_overrun), 64'd0);
        bus.data_in = 8'h04;
        tick(4);
        check("ovr_second_code", 64'(bus.ev_code), 64'd2);
        check("ovr_flag", 64'(bus.ev_overrun), 64'd1);
        bus.ev_ready = 1'b1;
        tick(1);
        check("ovr_drain_valid", 64'(bus.ev_valid), 64'd0);
        check("ovr_sticky", 64'(bus.ev_overrun), 64'd1);

        // Enable drop mid-settle restarts the full debounce.
        bus.data_in = 8'h20;
        tick(2);
        bus.enable = 1'b0;
        tick(3);
        check("en_low_data_out", 64'(bus.data_out), 64'd2);
        check("en_low_ev_valid", 64'(bus.ev_valid), 64'd0);
        bus.enable = 1'b1;
        tick(3);
        check("en_restart_early", 64'(bus.ev_valid), 64'd0);
        tick(1);
        check("en_commit_data_out", 64'(bus.data_out), 64'd5);
        check("en_commit_ev_valid", 64'(bus.ev_valid), 64'd1);
        tick(2);

        // Reset with an event pending and overrun set.
        bus.ev_ready = 1'b0;
        bus.data_in  = 8'h00;
        tick(4);
        bus.data_in = 8'h01;
        tick(4);
        check("pre_rst_overrun", 64'(bus.ev_overrun), 64'd1);
        bus.data_in = 8'h00;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        check("post_rst_ev_valid", 64'(bus.ev_valid), 64'd0);
        check("post_rst_overrun", 64'(bus.ev_overrun), 64'd0);
        check("post_rst_data_out", 64'(bus.data_out), 64'd0);
        check("post_rst_key_valid", 64'(bus.key_valid), 64'd0);

        // Random key traffic with variable hold times, ready and enable.
        for (int seg = 0; seg < 300; seg++) begin
            v = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            len = $urandom_range(1, 7);
            bus.data_in = v;
            for (int j = 0; j < len; j++) begin
                bus.ev_ready = ($urandom_range(0, 2) != 0);
                bus.enable   = ($urandom_range(0, 15) != 0);
                reset        = ($urandom_range(0, 199) == 0);
                tick(1);
            end
        end
        reset = 1'b0;
        bus.enable = 1'b1;
        bus.ev_ready = 1'b1;
        tick(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
